// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into
// word-granular accesses on a 1-cycle-latency data memory, using read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoadData,
    StMerge,
    StWrite,
    StResp
  } state_e;

  localparam logic [29:0] MemWordsW = 30'(MEM_WORDS);

  state_e      state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  // Request decode, only consulted in the accepting IDLE cycle.
  logic legal_f3, misaligned, out_of_range, dec_err, is_sw;

  always_comb begin
    if (req_is_store) begin
      legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      legal_f3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = req_addr[31:2] >= MemWordsW;
    dec_err      = !legal_f3 || misaligned || out_of_range;
    is_sw        = req_is_store && (req_funct3 == 3'b010);
  end

  // Lane extraction for loads and lane insertion for sub-word stores, from latched fields.
  logic [4:0]  lane_sh;
  logic [31:0] shifted, load_ext, lane_mask, merged;

  always_comb begin
    lane_sh = {off_q, 3'b000};
    shifted = mem_rdata >> lane_sh;
    unique case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
    lane_mask = (funct3_q[1:0] == 2'b00) ? (32'h0000_00ff << lane_sh)
                                         : (32'h0000_ffff << lane_sh);
    merged    = (mem_rdata & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'h0;
      mem_read       <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_addr       <= 32'h0;
      mem_write_data <= 32'h0;
      is_store_q     <= 1'b0;
      funct3_q       <= 3'b000;
      off_q          <= 2'b00;
      wdata_q        <= 32'h0;
    end else begin
      // Strobes are single-cycle unless the case below re-asserts them.
      resp_valid   <= 1'b0;
      mem_read     <= 1'b0;
      mem_write_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            off_q      <= req_addr[1:0];
            wdata_q    <= req_wdata;
            mem_addr   <= {req_addr[31:2], 2'b00};
            req_ready  <= 1'b0;
            if (dec_err) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (is_sw) begin
              state_q        <= StWrite;
              mem_write_en   <= 1'b1;
              mem_write_data <= req_wdata;
            end else begin
              state_q  <= StRead;
              mem_read <= 1'b1;
            end
          end
        end
        StRead: begin
          state_q <= is_store_q ? StMerge : StLoadData;
        end
        StLoadData: begin
          state_q    <= StResp;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_ext;
        end
        StMerge: begin
          state_q        <= StWrite;
          mem_write_en   <= 1'b1;
          mem_write_data <= merged;
        end
        StWrite: begin
          state_q    <= StResp;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        StResp: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset/backpressure sequences and
// randomized requests checked against a byte-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_rdata;
  logic        mem_read, mem_write_en;
  logic        preload = 1'b1;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory with registered read data.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[1] <= 32'hDEADBEEF;
      mem[2] <= 32'hCAFEBABE;
    end else begin
      if (mem_read) mem_rdata <= mem[mem_addr[11:2]];
      if (mem_write_en) mem[mem_addr[11:2]] <= mem_write_data;
    end
  end

  logic [31:0] ref_mem [0:1023];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model built from byte-level rules; updates ref_mem on stores.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic err,
                                output logic [31:0] rd, output int lat, output int nrd,
                                output int nwr, output logic [31:0] ww);
    int unsigned idx = a[31:2];
    int unsigned off = a[1:0];
    int nbytes = 1 << f3[1:0];
    logic legal;
    logic [31:0] w, v;
    legal = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    err = !legal || ((a % nbytes) != 0) || (idx >= 1024);
    rd = 0; ww = 0; nwr = 0; nrd = 0;
    if (err) begin
      lat = 1;
      return;
    end
    w = ref_mem[idx];
    if (!st) begin
      v = 0;
      for (int b = 0; b < nbytes; b++) v[8*b +: 8] = w[8*(off+b) +: 8];
      if (!f3[2] && v[8*nbytes-1])
        for (int b = nbytes; b < 4; b++) v[8*b +: 8] = 8'hFF;
      rd = v; lat = 3; nrd = 1;
    end else begin
      v = w;
      for (int b = 0; b < nbytes; b++) v[8*(off+b) +: 8] = wd[8*b +: 8];
      ww = v; nwr = 1; ref_mem[idx] = v;
      lat = (nbytes == 4) ? 2 : 4;
      nrd = (nbytes == 4) ? 0 : 1;
    end
  endfunction

  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd,
                         output int lat, output int nrd, output int nwr,
                         output logic [31:0] ww, output logic [31:0] raddr);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; ww = 0; raddr = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_read) begin nrd++; raddr = mem_addr; end
      if (mem_write_en) begin nwr++; ww = mem_write_data; end
    end while (!resp_valid && lat < 20);
    err = resp_err;
    rd = resp_rdata;
  endtask

  typedef struct {
    logic st; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
    logic err; logic [31:0] rdata; int lat; int nrd; int nwr; logic [31:0] wword;
  } vec_t;

  initial begin
    vec_t vecs[13];
    logic e, me; logic [31:0] r, mr, w, mw, ra;
    int l, ml, nr, mnr, nw, mnw, cnt_wr, cnt_resp, cnt_acc, bad_words;
    logic [2:0] f3; logic [31:0] a;
    logic [2:0] legal_ld [5];

    legal_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    vecs[0]  = '{0, 3'b010, 32'h4, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0, 32'h0};
    vecs[1]  = '{0, 3'b000, 32'h7, 32'h0, 0, 32'hFFFFFFDE, 3, 1, 0, 32'h0};
    vecs[2]  = '{0, 3'b100, 32'h7, 32'h0, 0, 32'h000000DE, 3, 1, 0, 32'h0};
    vecs[3]  = '{0, 3'b001, 32'h6, 32'h0, 0, 32'hFFFFDEAD, 3, 1, 0, 32'h0};
    vecs[4]  = '{0, 3'b101, 32'h4, 32'h0, 0, 32'h0000BEEF, 3, 1, 0, 32'h0};
    vecs[5]  = '{0, 3'b000, 32'h4, 32'h0, 0, 32'hFFFFFFEF, 3, 1, 0, 32'h0};
    vecs[6]  = '{1, 3'b000, 32'h9, 32'h12345678, 0, 32'h0, 4, 1, 1, 32'hCAFE78BE};
    vecs[7]  = '{1, 3'b001, 32'hA, 32'hAAAA5555, 0, 32'h0, 4, 1, 1, 32'h555578BE};
    vecs[8]  = '{0, 3'b010, 32'h8, 32'h0, 0, 32'h555578BE, 3, 1, 0, 32'h0};
    vecs[9]  = '{0, 3'b010, 32'h6, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0};
    vecs[10] = '{1, 3'b001, 32'h3, 32'h0000FFFF, 1, 32'h0, 1, 0, 0, 32'h0};
    vecs[11] = '{0, 3'b011, 32'h4, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0};
    vecs[12] = '{1, 3'b010, 32'h1000, 32'h11111111, 1, 32'h0, 1, 0, 0, 32'h0};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[1] = 32'hDEADBEEF;
    ref_mem[2] = 32'hCAFEBABE;

    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_strobes", {30'h0, mem_read, mem_write_en}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_write_data, 32'h0);
    preload = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      model(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, me, mr, ml, mnr, mnw, mw);
      run_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, e, r, l, nr, nw, w, ra);
      chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vecs[i].err});
      chk($sformatf("vec%0d_rdata", i), r, vecs[i].rdata);
      chk($sformatf("vec%0d_latency", i), l, vecs[i].lat);
      chk($sformatf("vec%0d_reads", i), nr, vecs[i].nrd);
      chk($sformatf("vec%0d_writes", i), nw, vecs[i].nwr);
      if (vecs[i].nwr > 0) chk($sformatf("vec%0d_wword", i), w, vecs[i].wword);
      if (vecs[i].nrd > 0) chk($sformatf("vec%0d_maddr", i), ra, {vecs[i].addr[31:2], 2'b00});
    end
    chk("errors_left_mem", mem[1], 32'hDEADBEEF);

    // Reset while the SB 0x8 read-modify-write sits in MERGE.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h8; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_async_wen", {31'h0, mem_write_en}, 32'h0);
    cnt_wr = 0; cnt_resp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (mem_write_en) cnt_wr++;
      if (resp_valid) cnt_resp++;
    end
    chk("rst_no_write", cnt_wr, 0);
    chk("rst_no_resp", cnt_resp, 0);
    chk("rst_ready_after", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_unchanged", mem[2], 32'h555578BE);

    // req_valid held high: one accept per IDLE cycle, LW spacing of 4 cycles.
    cnt_acc = 0; cnt_resp = 0;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) cnt_acc++;
      @(negedge clk);
      if (resp_valid) cnt_resp++;
    end
    req_valid = 1'b0;
    chk("held_valid_accepts", cnt_acc, 3);
    chk("held_valid_resps", cnt_resp, 3);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                       : legal_ld[$urandom_range(0, 4)];
      a[1:0] = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 19))
        0:       a[31:2] = 30'(1024 + $urandom_range(0, 100));
        1:       a[31:2] = 30'd1023;
        default: a[31:2] = 30'($urandom_range(0, 15));
      endcase
      w = $urandom;
      e = 1'($urandom_range(0, 1));
      model(e, f3, a, w, me, mr, ml, mnr, mnw, mw);
      run_req(e, f3, a, w, e, r, l, nr, nw, w, ra);
      chk($sformatf("rnd%0d_err", i), {31'h0, e}, {31'h0, me});
      chk($sformatf("rnd%0d_rdata", i), r, mr);
      chk($sformatf("rnd%0d_latency", i), l, ml);
      chk($sformatf("rnd%0d_reads", i), nr, mnr);
      chk($sformatf("rnd%0d_writes", i), nw, mnw);
      if (mnw > 0) chk($sformatf("rnd%0d_wword", i), w, mw);
      if (mnr > 0) chk($sformatf("rnd%0d_maddr", i), ra, {a[31:2], 2'b00});
    end

    @(negedge clk);
    bad_words = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad_words++;
    chk("mem_image", bad_words, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute/memory stage and the word-addressed data memory, directly upstream of it.
- Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-granular memory accesses.
- Handles load sign/zero extension, sub-word stores by read-modify-write, and misaligned or out-of-range detection.
- Owns the memory's addr, write_en, write_data and mem_read inputs, and consumes its data_out (registered, 1-cycle read latency).

Parameters:
- MEM_WORDS, 1024: number of 32-bit words in data memory. Word index = addr[31:2]; valid range 0..MEM_WORDS-1.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready at a clk edge
- req_is_store  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 (size/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; lane data in low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: misaligned, illegal funct3, or out of range
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_addr  out  32  {word_index, 2'b00} to memory
- mem_read  out  1  memory read strobe
- mem_write_en  out  1  memory write strobe, full word
- mem_write_data  out  32  full word to write
- mem_rdata  in  32  memory data_out; valid the cycle after mem_read

Behaviour:
- Reset values: state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_read=0, mem_write_en=0; mem_addr=0, mem_write_data=0.
- Reset takes effect immediately and asynchronously. A reset mid-operation discards the request: no write strobe, no response.
- Decode at acceptance; request fields are latched.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Out of range: addr[31:2] >= MEM_WORDS.
- mem_* outputs are decoded from the state and latched registers only; there is no combinational path from req_* to mem_*.
- req_ready=1 only in IDLE. req_valid in other states is ignored.
- FSM states:
  - IDLE: on accept, go to RESP (error case), READ (load, or SB/SH), or WRITE (SW).
  - READ: mem_read=1. Next state is LOAD_DATA for a load, MERGE for a store.
  - LOAD_DATA: select the byte/half lane by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), register the result into resp_rdata. Go to RESP.
  - MERGE: replace lane addr[1:0] of mem_rdata with req_wdata[7:0] (SB) or req_wdata[15:0] (SH). Register the merged word. No strobes. Go to WRITE.
  - WRITE: mem_write_en=1 for exactly one cycle; mem_write_data = merged word (SB/SH) or req_wdata (SW). Go to RESP.
  - RESP: resp_valid=1 for one cycle, resp_err as decoded. Go to IDLE.
- Latency from the accept edge: error 1 cycle; SW 2; load 3; SB/SH 4. This is the cycle in which resp_valid is high.
- Error requests never assert mem_read or mem_write_en.
- resp_rdata and resp_err hold their values until the next RESP. There is no response backpressure.
- Back-to-back operation: a new request can be accepted in the IDLE cycle immediately after RESP.

Test Plan:
- Memory model: 1-cycle-latency word memory preloaded with 0x4=0xDEADBEEF, 0x8=0xCAFEBABE.
- LW 0x4 -> resp_valid 3 cycles after accept, resp_rdata=0xDEADBEEF, resp_err=0; exactly one mem_read pulse with mem_addr=0x4.
- Sub-word loads:
  - LB 0x7 -> 0xFFFFFFDE
  - LBU 0x7 -> 0x000000DE
  - LH 0x6 -> 0xFFFFDEAD
  - LHU 0x4 -> 0x0000BEEF
  - LB 0x4 -> 0xFFFFFFEF
- Sub-word stores:
  - SB 0x9, wdata 0x12345678 -> single mem_write_en pulse, mem_write_data=0xCAFE78BE, resp 4 cycles after accept.
  - Then SH 0xA, wdata 0xAAAA5555 -> write 0x555578BE.
  - Then LW 0x8 -> 0x555578BE.
- Errors:
  - LW 0x6, SH 0x3, funct3=011, and SW 0x1000 (MEM_WORDS=1024) -> resp_valid+resp_err 1 cycle after accept.
  - No mem_read or mem_write_en in any of these cases; memory unchanged.
- Reset and backpressure:
  - rst_n pulled low during MERGE of SB 0x8 -> mem_write_en never asserts, 0x8 unchanged, no resp_valid, req_ready=1 after release.
  - req_valid held high while busy -> only one request is accepted per IDLE cycle.
